knight_move_gen: RTL and testbench

//  Sequential knight move generator for the chess engine datapath. One start request runs through all 8 knight directions, one per clock.
//  For each target it decides whether the knight can land there (on-board, and empty or enemy-occupied).

---
 rtl/knight_move_gen.sv | 242 ++++++++++++++++++++++++
 tb/tb_knight_move_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/knight_move_gen.sv
// Knight move generator: start -> 8 directions, then legal/capture masks + count.
// Latency: start sampled at edge E0, done high for one cycle after edge E9.
// Backpressure: none; start is accepted only in IDLE, otherwise dropped (no queuing).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               request pulse (honoured in IDLE only)
//   board[64*SQ_BITS]   packed board, square i = board[SQ_BITS*i +: SQ_BITS], i = row*8+col
//   from_pos[5:0]       knight square, side = mover colour (0 white, 1 black)
//   busy, done          busy from accept until done; done is a one-cycle pulse
//   move_mask[63:0]     legal landing squares
//   capture_mask[63:0]  landing squares holding an enemy piece
//   move_count[3:0]     popcount of move_mask
//   protect_mask[63:0]  same-colour pieces a knight defends (only with KMG_PROTECT_MASK_EN)
//
// Optional feature macro: KMG_PROTECT_MASK_EN.

module knight_move_gen #(
  parameter int SQ_BITS  = 4,
  parameter int NUM_DIRS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [64*SQ_BITS-1:0]   board,
  input  logic [5:0]              from_pos,
  input  logic                    side,
  output logic                    busy,
  output logic                    done,
  output logic [63:0]             move_mask,
  output logic [63:0]             capture_mask,
  output logic [3:0]              move_count
`ifdef KMG_PROTECT_MASK_EN
  ,
  output logic [63:0]             protect_mask
`endif
);

  // Counter must reach NUM_DIRS itself: that value marks the write-back-only cycle.
  localparam int DIR_W = $clog2(NUM_DIRS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  w_accept;
  logic                  w_issue;

  logic [64*SQ_BITS-1:0] r_board;
  logic [5:0]            r_from;
  logic                  r_side;
  logic [DIR_W-1:0]      r_dir;

  logic signed [4:0]     w_drow;
  logic signed [4:0]     w_dcol;
  logic signed [4:0]     w_row;
  logic signed [4:0]     w_col;
  logic                  w_on_board;
  logic [5:0]            w_tgt_idx;
  logic [SQ_BITS-1:0]    w_tgt_sq;
  logic                  w_occupied;
  logic                  w_friend;
  logic                  w_enemy;

  // Stage between the board lookup and the mask update. The lookup is a
  // 64:1 mux of the latched board followed by a colour compare, so it is
  // registered before touching the masks; this is why SCAN runs one cycle
  // past the last direction.
  logic                  r_stg_land;
  logic                  r_stg_cap;
  logic [5:0]            r_stg_idx;

  logic [63:0]           r_move_mask;
  logic [63:0]           r_cap_mask;
  logic [3:0]            r_count;

`ifdef KMG_PROTECT_MASK_EN
  logic                  r_stg_prot;
  logic [63:0]           r_prot_mask;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (r_dir == DIR_W'(NUM_DIRS)) begin
          // Last direction is being written back on this edge.
          w_state_nxt = S_DONE;
        end else begin
          w_issue = 1'b1;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------ request latch / dir
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_board <= '0;
      r_from  <= '0;
      r_side  <= 1'b0;
      r_dir   <= '0;
    end else if (w_accept) begin
      r_board <= board;
      r_from  <= from_pos;
      r_side  <= side;
      r_dir   <= '0;
    end else if (w_issue) begin
      r_dir   <= r_dir + 1'b1;
    end
  end

  // ------------------------------------------------ target computation
  always_comb begin
    w_drow = 5'sd0;
    w_dcol = 5'sd0;
    case (r_dir[2:0])
      3'd0: begin w_drow = -5'sd1; w_dcol = -5'sd2; end
      3'd1: begin w_drow = -5'sd2; w_dcol = -5'sd1; end
      3'd2: begin w_drow = -5'sd2; w_dcol =  5'sd1; end
      3'd3: begin w_drow = -5'sd1; w_dcol =  5'sd2; end
      3'd4: begin w_drow =  5'sd1; w_dcol =  5'sd2; end
      3'd5: begin w_drow =  5'sd2; w_dcol =  5'sd1; end
      3'd6: begin w_drow =  5'sd2; w_dcol = -5'sd1; end
      3'd7: begin w_drow =  5'sd1; w_dcol = -5'sd2; end
      default: begin w_drow = 5'sd0; w_dcol = 5'sd0; end
    endcase
  end

  // Row and column are handled separately so a move off one edge can never
  // reappear on the opposite edge of a neighbouring row.
  assign w_row      = $signed({2'b00, r_from[5:3]}) + w_drow;
  assign w_col      = $signed({2'b00, r_from[2:0]}) + w_dcol;
  // 0..7 in 5-bit signed means the top two bits are both clear.
  assign w_on_board = (w_row[4:3] == 2'b00) && (w_col[4:3] == 2'b00);
  assign w_tgt_idx  = {w_row[2:0], w_col[2:0]};

  always_comb begin
    w_tgt_sq = '0;
    for (int i = 0; i < 64; i++) begin
      if (w_tgt_idx == 6'(i)) begin
        w_tgt_sq = r_board[i*SQ_BITS +: SQ_BITS];
      end
    end
  end

  assign w_occupied = |w_tgt_sq;
  assign w_friend   = w_occupied && (w_tgt_sq[SQ_BITS-1] == r_side);
  assign w_enemy    = w_occupied && (w_tgt_sq[SQ_BITS-1] != r_side);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_land <= 1'b0;
      r_stg_cap  <= 1'b0;
      r_stg_idx  <= '0;
    end else begin
      r_stg_land <= w_issue && w_on_board && !w_friend;
      r_stg_cap  <= w_issue && w_on_board && w_enemy;
      r_stg_idx  <= w_tgt_idx;
    end
  end

  // ------------------------------------------------ result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_move_mask <= '0;
      r_cap_mask  <= '0;
      r_count     <= '0;
    end else if (w_accept) begin
      r_move_mask <= '0;
      r_cap_mask  <= '0;
      r_count     <= '0;
    end else begin
      if (r_stg_land) begin
        r_move_mask[r_stg_idx] <= 1'b1;
        r_count                <= r_count + 1'b1;
      end
      if (r_stg_cap) begin
        r_cap_mask[r_stg_idx]  <= 1'b1;
      end
    end
  end

  assign move_mask    = r_move_mask;
  assign capture_mask = r_cap_mask;
  assign move_count   = r_count;

`ifdef KMG_PROTECT_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_prot <= 1'b0;
    end else begin
      r_stg_prot <= w_issue && w_on_board && w_friend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prot_mask <= '0;
    end else if (w_accept) begin
      r_prot_mask <= '0;
    end else if (r_stg_prot) begin
      r_prot_mask[r_stg_idx] <= 1'b1;
    end
  end

  assign protect_mask = r_prot_mask;
`endif

endmodule

// File: tb/tb_knight_move_gen.sv
// Testbench for knight_move_gen: directed cases plus randomized boards
// compared against a row/column arithmetic reference model.
// Optional feature macro: KMG_PROTECT_MASK_EN (adds protect_mask checks).

module tb_knight_move_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] board;
  logic [5:0]   from_pos;
  logic         side;
  logic         busy;
  logic         done;
  logic [63:0]  move_mask;
  logic [63:0]  capture_mask;
  logic [3:0]   move_count;
`ifdef KMG_PROTECT_MASK_EN
  logic [63:0]  protect_mask;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  knight_move_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .board        (board),
    .from_pos     (from_pos),
    .side         (side),
    .busy         (busy),
    .done         (done),
    .move_mask    (move_mask),
    .capture_mask (capture_mask),
    .move_count   (move_count)
`ifdef KMG_PROTECT_MASK_EN
    ,
    .protect_mask (protect_mask)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: enumerate the eight knight offsets on an 8x8 grid.
  function automatic void ref_moves(input logic [255:0] b, input int fr, input logic sd,
                                    output logic [63:0] mv, output logic [63:0] cp,
                                    output logic [63:0] pr);
    int dr[8] = '{-2, -2, -1, -1, 1, 1, 2, 2};
    int dc[8] = '{-1,  1, -2,  2, -2, 2, -1, 1};
    int r;
    int c;
    int t;
    logic [3:0] q;
    mv = '0;
    cp = '0;
    pr = '0;
    for (int k = 0; k < 8; k++) begin
      r = fr / 8 + dr[k];
      c = fr % 8 + dc[k];
      if (r >= 0 && r <= 7 && c >= 0 && c <= 7) begin
        t = r * 8 + c;
        q = b[4*t +: 4];
        if (q == 4'h0) begin
          mv[t] = 1'b1;
        end else if (q[3] != sd) begin
          mv[t] = 1'b1;
          cp[t] = 1'b1;
        end else begin
          pr[t] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [255:0] rand_board();
    logic [255:0] b;
    logic [2:0]   ty;
    b = '0;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        ty = 3'($urandom_range(7, 1));
        b[4*i +: 4] = {1'($urandom_range(1, 0)), ty};
      end
    end
    return b;
  endfunction

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    chk(tag, 64'(n), 64'd0);
  endtask

  // Issues one request and checks timing and results. With disturb set,
  // a second start and altered inputs are driven while the scan runs.
  task automatic run_case(input string tag, input logic [255:0] b, input logic [5:0] fr,
                          input logic sd, input logic [63:0] exp_mv, input logic [63:0] exp_cp,
                          input logic [63:0] exp_pr, input int exp_cnt, input bit disturb);
    int lat;
    lat = 0;
    @(negedge clk);
    board    = b;
    from_pos = fr;
    side     = sd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (disturb && cyc == 3) begin
        start    = 1'b1;
        board    = ~b;
        from_pos = fr ^ 6'h2a;
        side     = ~sd;
      end
      if (disturb && cyc == 5) start = 1'b0;
      @(posedge clk);
      #1;
      if (cyc == 4) chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
      if (done) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd9);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_move_mask"}, move_mask, exp_mv);
    chk({tag, "_capture_mask"}, capture_mask, exp_cp);
    chk({tag, "_move_count"}, 64'(move_count), 64'(exp_cnt));
`ifdef KMG_PROTECT_MASK_EN
    chk({tag, "_protect_mask"}, protect_mask, exp_pr);
`else
    if (exp_pr === 64'hx) $display("note: unexpected x in protect expectation");
`endif
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, 64'(done), 64'd0);
    chk({tag, "_hold_mask"}, move_mask, exp_mv);
    if (disturb) count_dones({tag, "_extra_done"}, 12);
  endtask

  task automatic run_model_case(input string tag, input logic [255:0] b, input logic [5:0] fr,
                                input logic sd, input bit disturb);
    logic [63:0] mv;
    logic [63:0] cp;
    logic [63:0] pr;
    ref_moves(b, int'(fr), sd, mv, cp, pr);
    run_case(tag, b, fr, sd, mv, cp, pr, $countones(mv), disturb);
  endtask

  initial begin
    logic [255:0] b;
    logic [63:0]  mv;
    rst      = 1'b1;
    start    = 1'b0;
    board    = '0;
    from_pos = '0;
    side     = 1'b0;
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_move_mask", move_mask, 64'd0);
    chk("reset_capture_mask", capture_mask, 64'd0);
    chk("reset_move_count", 64'(move_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Corner square on an empty board.
    mv = '0; mv[10] = 1'b1; mv[17] = 1'b1;
    run_case("corner0", '0, 6'd0, 1'b0, mv, 64'd0, 64'd0, 2, 1'b0);

    // Centre square, all eight targets.
    mv = '0;
    mv[10] = 1'b1; mv[12] = 1'b1; mv[17] = 1'b1; mv[21] = 1'b1;
    mv[33] = 1'b1; mv[37] = 1'b1; mv[42] = 1'b1; mv[44] = 1'b1;
    run_case("centre27", '0, 6'd27, 1'b0, mv, 64'd0, 64'd0, 8, 1'b0);

    // Enemy on 10, friend on 12.
    b = '0;
    b[4*10 +: 4] = 4'h9;
    b[4*12 +: 4] = 4'h1;
    mv[12] = 1'b0;
    run_case("capture27", b, 6'd27, 1'b0, mv, 64'h0000_0000_0000_0400,
             64'h0000_0000_0000_1000, 7, 1'b0);

    // Right edge: targets must not wrap onto column 0 of the next rows.
    mv = '0; mv[13] = 1'b1; mv[22] = 1'b1;
    run_case("edge7", '0, 6'd7, 1'b0, mv, 64'd0, 64'd0, 2, 1'b0);

    // Black mover, left edge on the far row.
    run_model_case("black56", rand_board(), 6'd56, 1'b1, 1'b0);

    // Start and input changes during the scan are ignored.
    run_model_case("disturb", rand_board(), 6'($urandom_range(63, 0)), 1'($urandom_range(1, 0)), 1'b1);

    // Reset part-way through the scan.
    @(negedge clk);
    board    = '0;
    from_pos = 6'd27;
    side     = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_move_mask", move_mask, 64'd0);
    chk("midrst_capture_mask", capture_mask, 64'd0);
    chk("midrst_move_count", 64'(move_count), 64'd0);
`ifdef KMG_PROTECT_MASK_EN
    chk("midrst_protect_mask", protect_mask, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    count_dones("midrst_no_done", 12);
    run_model_case("after_rst", rand_board(), 6'd27, 1'b0, 1'b0);

    // Random boards, squares and sides.
    for (int n = 0; n < 25; n++) begin
      run_model_case("random", rand_board(), 6'($urandom_range(63, 0)), 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
